// File: rtl/spi_word_tx.sv
// rtl/spi_word_tx.sv - FIFO-buffered MSB-first SPI word transmitter for the instruction-load port.
// Define SPI_TX_PARITY_EN to append an even-parity bit to every frame.
module spi_word_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic                  word_valid_i,
  output logic                  word_ready_o,
  output logic                  spi_ss_o,
  output logic                  spi_mosi_o,
  output logic                  busy_o,
  output logic                  fifo_empty_o,
  output logic [15:0]           words_sent_o
);

`ifdef SPI_TX_PARITY_EN
  localparam int SW = DATA_WIDTH + 1;
`else
  localparam int SW = DATA_WIDTH;
`endif
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(SW + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SW - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [1:0]            state;
  logic [SW-2:0]         shreg;
  logic [BW-1:0]         bit_cnt;
  logic [GW-1:0]         gap_cnt;
  logic [DATA_WIDTH-1:0] head;
  logic [SW-1:0]         head_frame;

  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign word_ready_o = !full;
  assign fifo_empty_o = empty;
  assign push         = word_valid_i && !full;
  assign head         = mem[rd_ptr[AW-1:0]];
`ifdef SPI_TX_PARITY_EN
  assign head_frame   = {head, ^head};
`else
  assign head_frame   = head;
`endif

  // A new frame starts from IDLE or on the last gap cycle; en_i never cuts a frame short.
  assign pop    = en_i && !empty &&
                  ((state == S_IDLE) || ((state == S_GAP) && (gap_cnt == GAP_LAST)));
  assign busy_o = (state != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= word_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      state        <= S_IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      spi_ss_o     <= 1'b1;
      spi_mosi_o   <= 1'b0;
      words_sent_o <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        // The MSB goes straight to mosi; shreg holds the bits still to come.
        rd_ptr     <= rd_ptr + (AW+1)'(1);
        shreg      <= head_frame[SW-2:0];
        bit_cnt    <= '0;
        state      <= S_SHIFT;
        spi_ss_o   <= 1'b0;
        spi_mosi_o <= head_frame[SW-1];
      end else begin
        case (state)
          S_SHIFT: begin
            if (bit_cnt == BIT_LAST) begin
              state        <= S_GAP;
              gap_cnt      <= '0;
              spi_ss_o     <= 1'b1;
              spi_mosi_o   <= 1'b0;
              words_sent_o <= words_sent_o + 16'd1;
            end else begin
              bit_cnt    <= bit_cnt + BW'(1);
              shreg      <= {shreg[SW-3:0], 1'b0};
              spi_mosi_o <= shreg[SW-2];
            end
          end
          S_GAP: begin
            if (gap_cnt == GAP_LAST) begin
              state <= S_IDLE;
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/spi_word_tx.md
Name: spi_word_tx

Overview:
- SPI-style word transmitter; the driving end of the SoC's SPI instruction-load port (spi_ss / spi_mosi).
- Accepts DATA_WIDTH-bit words over a valid/ready interface and buffers them in a small FIFO.
- Serializes each word MSB-first, one bit per clk_i cycle, framed by active-low spi_ss.
- Used as the on-chip or FPGA-side loader that replaces a bench-driven bitstream for ICCM loading.

Parameters:
- DATA_WIDTH, 32, bits per word and per frame.
- FIFO_DEPTH, 4, input FIFO entries; power of two, minimum 2.
- GAP_CYCLES, 4, cycles spi_ss is held high between consecutive frames; minimum 1.

Ports:
- clk_i  input  1  system clock; all logic on its rising edge.
- rst_i  input  1  synchronous reset, active-high.
- en_i  input  1  transmit enable; gates the start of new frames only.
- word_i  input  DATA_WIDTH  word to transmit.
- word_valid_i  input  1  word_i is valid.
- word_ready_o  output  1  FIFO can accept a word (= !full).
- spi_ss_o  output  1  frame select, active-low, registered.
- spi_mosi_o  output  1  serial data, MSB first, registered.
- busy_o  output  1  high in SHIFT or GAP.
- fifo_empty_o  output  1  FIFO empty.
- words_sent_o  output  16  count of completed frames; wraps.

Behaviour:
- Reset, sampled on the rising edge while rst_i=1:
  - spi_ss_o=1, spi_mosi_o=0, busy_o=0, words_sent_o=0.
  - FIFO emptied, so fifo_empty_o=1 and word_ready_o=1.
  - FSM returns to IDLE.
  - Reset mid-frame aborts the frame; spi_ss_o=1 on the next cycle and the partial word is discarded and not counted.
- FIFO:
  - Push when word_valid_i && word_ready_o.
  - Pop only in the FSM load event below. There is no bypass: a word pushed into an empty FIFO is poppable the following cycle.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - When full, word_ready_o=0 and word_valid_i is ignored.
  - Pointers are log2(FIFO_DEPTH)+1 bits, with the wrap bit distinguishing full from empty.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: ss=1, mosi=0. If en_i && !empty, pop the FIFO into the shift register, clear the bit counter and go to SHIFT.
  - SHIFT: ss=0, mosi=shreg[DATA_WIDTH-1]; shift left each cycle; lasts exactly DATA_WIDTH cycles. On the last bit, increment words_sent_o (16-bit wrap, 0xFFFF->0x0000) and go to GAP.
  - GAP: ss=1, mosi=0 for exactly GAP_CYCLES cycles. At the end: if en_i && !empty, pop and go to SHIFT; otherwise go to IDLE.
- Latency: word pushed at cycle t into an empty FIFO in IDLE with en_i=1:
  - pop at t+1;
  - spi_ss_o=0 and spi_mosi_o=word[31] visible from t+2;
  - word[0] at t+33;
  - spi_ss_o=1 at t+34.
- Back-to-back frames: ss is low for DATA_WIDTH cycles, then high for exactly GAP_CYCLES cycles, then low again.
- en_i deasserted mid-frame: the current frame and gap complete, then the FSM holds in IDLE. FIFO contents are retained.
- busy_o is high in SHIFT and GAP.

Optional Feature:
- Macro: SPI_TX_PARITY_EN.
- Defined:
  - SHIFT lasts DATA_WIDTH+1 cycles.
  - The extra final bit is even parity (XOR of all DATA_WIDTH data bits), driven with ss still low.
  - words_sent_o increments on the parity bit.
- Undefined: no parity bit; frame is exactly DATA_WIDTH cycles.

Test Plan:
1. Reset, en_i=1, push 0xA5A5_0F0F once:
   - spi_ss_o low for exactly 32 cycles starting 2 cycles after the push;
   - mosi sequence 1,0,1,0,0,1,0,1,... ending ...1,1,1,1;
   - words_sent_o=1.
2. Push 0x0000_0001, 0xFFFF_FFFF, 0x8000_0000 back-to-back with en_i=1:
   - three frames, each separated by exactly 4 ss-high cycles;
   - the mosi bits match each word MSB-first;
   - words_sent_o=3.
3. en_i=0, push 5 words:
   - word_ready_o drops after the 4th push and the 5th is held;
   - no ss activity.
   Then set en_i=1:
   - the 5th push is accepted once the first pop occurs;
   - 5 frames in order.
4. Assert rst_i for 1 cycle during bit 10 of a frame:
   - spi_ss_o=1 and spi_mosi_o=0 the next cycle;
   - FIFO empty, words_sent_o=0;
   - no further frames.
5. Drop en_i during bit 5 of frame 1 with 2 words queued:
   - frame 1 completes, the gap completes, ss stays high;
   - fifo holds 2 entries.
   Then raise en_i:
   - the remaining 2 frames are sent.
6. Preload words_sent_o to 0xFFFF via 65535 frames (or force), then send 1 word:
   - count wraps to 0x0000.
   With SPI_TX_PARITY_EN, word 0x0000_0007:
   - 33 low-ss cycles, final bit=1.
